// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : morse_pkg
// Brief    : Shared symbol encoding, FSM states and ASCII codes for the decoder.
// Revision : 1.0
// ============================================================================
package morse_pkg;

    localparam logic       SYM_DOT     = 1'b0;
    localparam logic       SYM_DASH    = 1'b1;
    localparam logic [2:0] MAX_SYMBOLS = 3'd5;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_NUL   = 8'h00;

    typedef enum logic [1:0] {
        COLLECT    = 2'd0,
        EMIT_CHAR  = 2'd1,
        EMIT_SPACE = 2'd2
    } state_t;

endpackage : morse_pkg
`default_nettype wire

// File: rtl/morse_lut.sv
`default_nettype none
// ============================================================================
// Module   : morse_lut
// Brief    : Combinational ITU Morse lookup (A-Z, 0-9); first symbol at bit len-1.
// Revision : 1.0
// ============================================================================
module morse_lut
    import morse_pkg::*;
#(
    parameter logic [7:0] UNKNOWN_CHAR = ASCII_QMARK
) (
    input  logic [2:0] len_i,
    input  logic [4:0] pattern_i,
    output logic [7:0] char_o
);

    logic [4:0] w_mask;
    logic [7:0] w_key;

    // Bits above len may hold stale data, so they are masked off before matching.
    always_comb begin
        case (len_i)
            3'd1:    w_mask = 5'b00001;
            3'd2:    w_mask = 5'b00011;
            3'd3:    w_mask = 5'b00111;
            3'd4:    w_mask = 5'b01111;
            default: w_mask = 5'b11111;
        endcase
        w_key = {len_i, pattern_i & w_mask};
    end

    always_comb begin
        case (w_key)
            {3'd2, 5'b00001}: char_o = 8'h41; // A .-
            {3'd4, 5'b01000}: char_o = 8'h42; // B
            {3'd4, 5'b01010}: char_o = 8'h43; // C
            {3'd3, 5'b00100}: char_o = 8'h44; // D
            {3'd1, 5'b00000}: char_o = 8'h45; // E
            {3'd4, 5'b00010}: char_o = 8'h46; // F
            {3'd3, 5'b00110}: char_o = 8'h47; // G
            {3'd4, 5'b00000}: char_o = 8'h48; // H
            {3'd2, 5'b00000}: char_o = 8'h49; // I
            {3'd4, 5'b00111}: char_o = 8'h4A; // J
            {3'd3, 5'b00101}: char_o = 8'h4B; // K
            {3'd4, 5'b00100}: char_o = 8'h4C; // L
            {3'd2, 5'b00011}: char_o = 8'h4D; // M
            {3'd2, 5'b00010}: char_o = 8'h4E; // N
            {3'd3, 5'b00111}: char_o = 8'h4F; // O
            {3'd4, 5'b00110}: char_o = 8'h50; // P
            {3'd4, 5'b01101}: char_o = 8'h51; // Q
            {3'd3, 5'b00010}: char_o = 8'h52; // R
            {3'd3, 5'b00000}: char_o = 8'h53; // S
            {3'd1, 5'b00001}: char_o = 8'h54; // T
            {3'd3, 5'b00001}: char_o = 8'h55; // U
            {3'd4, 5'b00001}: char_o = 8'h56; // V
            {3'd3, 5'b00011}: char_o = 8'h57; // W
            {3'd4, 5'b01001}: char_o = 8'h58; // X
            {3'd4, 5'b01011}: char_o = 8'h59; // Y
            {3'd4, 5'b01100}: char_o = 8'h5A; // Z
            {3'd5, 5'b11111}: char_o = 8'h30; // 0
            {3'd5, 5'b01111}: char_o = 8'h31; // 1
            {3'd5, 5'b00111}: char_o = 8'h32; // 2
            {3'd5, 5'b00011}: char_o = 8'h33; // 3
            {3'd5, 5'b00001}: char_o = 8'h34; // 4
            {3'd5, 5'b00000}: char_o = 8'h35; // 5
            {3'd5, 5'b10000}: char_o = 8'h36; // 6
            {3'd5, 5'b11000}: char_o = 8'h37; // 7
            {3'd5, 5'b11100}: char_o = 8'h38; // 8
            {3'd5, 5'b11110}: char_o = 8'h39; // 9
            default:          char_o = UNKNOWN_CHAR;
        endcase
    end

endmodule : morse_lut
`default_nettype wire

// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_decoder
// Brief    : Collects dot/dash events into characters, decodes on gaps and
//            queues ASCII results in a show-ahead valid/ready FIFO.
// Revision : 1.0
// ============================================================================
module morse_decoder
    import morse_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] UNKNOWN_CHAR = ASCII_QMARK,
    parameter logic [7:0] SPACE_CHAR   = ASCII_SPACE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot,
    input  logic       dash,
    input  logic       interchar,
    input  logic       interword,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_char,
    output logic [2:0] pending_len,
    output logic       sym_overflow,
    output logic       lost
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic       dot_q, dash_q, ichar_q, iword_q;
    logic       w_dot_ev, w_dash_ev, w_sym_ev, w_char_ev, w_word_ev;

    state_t     state_q;
    logic [4:0] pattern_q;
    logic [2:0] len_q;
    logic       ovf_q, last_space_q, space_pend_q;

    logic [7:0] w_lut_char, w_wr_data;
    logic       w_wr_en;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [c_AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic          w_full, w_empty, w_pop, w_push;
    logic          lost_q;

    assign w_dot_ev  = dot       & ~dot_q;
    assign w_dash_ev = dash      & ~dash_q;
    assign w_char_ev = interchar & ~ichar_q;
    assign w_word_ev = interword & ~iword_q;
    assign w_sym_ev  = w_dot_ev | w_dash_ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            ichar_q <= 1'b0;
            iword_q <= 1'b0;
        end else begin
            dot_q   <= dot;
            dash_q  <= dash;
            ichar_q <= interchar;
            iword_q <= interword;
        end
    end

    morse_lut #(
        .UNKNOWN_CHAR(UNKNOWN_CHAR)
    ) u_lut (
        .len_i    (len_q),
        .pattern_i(pattern_q),
        .char_o   (w_lut_char)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= COLLECT;
            pattern_q    <= 5'd0;
            len_q        <= 3'd0;
            ovf_q        <= 1'b0;
            last_space_q <= 1'b1;
            space_pend_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    // A simultaneous dot and dash resolves to a dash.
                    if (w_sym_ev) begin
                        if (len_q == MAX_SYMBOLS || ovf_q) begin
                            ovf_q <= 1'b1;
                        end else begin
                            pattern_q <= {pattern_q[3:0], (w_dash_ev ? SYM_DASH : SYM_DOT)};
                            len_q     <= len_q + 3'd1;
                        end
                    end
                    if (w_word_ev) begin
                        if (len_q != 3'd0 || ovf_q) begin
                            state_q      <= EMIT_CHAR;
                            space_pend_q <= 1'b1;
                        end else if (!last_space_q) begin
                            state_q <= EMIT_SPACE;
                        end
                    end else if (w_char_ev && (len_q != 3'd0 || ovf_q)) begin
                        state_q      <= EMIT_CHAR;
                        space_pend_q <= 1'b0;
                    end
                end
                EMIT_CHAR: begin
                    pattern_q    <= 5'd0;
                    len_q        <= 3'd0;
                    ovf_q        <= 1'b0;
                    last_space_q <= 1'b0;
                    space_pend_q <= 1'b0;
                    state_q      <= space_pend_q ? EMIT_SPACE : COLLECT;
                end
                EMIT_SPACE: begin
                    last_space_q <= 1'b1;
                    state_q      <= COLLECT;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign w_wr_en   = (state_q == EMIT_CHAR) || (state_q == EMIT_SPACE);
    assign w_wr_data = (state_q == EMIT_SPACE) ? SPACE_CHAR :
                       (ovf_q ? UNKNOWN_CHAR : w_lut_char);

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                     (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    assign w_pop   = ~w_empty & out_ready;
    assign w_push  = w_wr_en & (~w_full | w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{c_AW{1'b0}}, w_push};
        rd_ptr_d = rd_ptr_q + {{c_AW{1'b0}}, w_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lost_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (w_wr_en && w_full && !w_pop) begin
                lost_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= w_wr_data;
        end
    end

    assign out_valid    = ~w_empty;
    assign out_char     = w_empty ? ASCII_NUL : mem_q[rd_ptr_q[c_AW-1:0]];
    assign pending_len  = len_q;
    assign sym_overflow = ovf_q;
    assign lost         = lost_q;

endmodule : morse_decoder
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_decoder
// Brief    : Table-driven and directed self-checking bench for morse_decoder.
// Revision : 1.0
// ============================================================================
module tb_morse_decoder;

    logic       clk = 1'b0;
    logic       reset, dot, dash, interchar, interword, out_ready;
    logic       out_valid, sym_overflow, lost;
    logic [7:0] out_char;
    logic [2:0] pending_len;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];

    typedef struct {
        int         n;
        logic [4:0] pat;
        bit         word;
        int         nexp;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t vecs [11];

    morse_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .dot         (dot),
        .dash        (dash),
        .interchar   (interchar),
        .interword   (interword),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_char    (out_char),
        .pending_len (pending_len),
        .sym_overflow(sym_overflow),
        .lost        (lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) got_q.push_back(out_char);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic is_dash);
        @(posedge clk); #1;
        dot  = ~is_dash;
        dash = is_dash;
        @(posedge clk); #1;
        dot  = 1'b0;
        dash = 1'b0;
    endtask

    task automatic gap(input bit word);
        @(posedge clk); #1;
        if (word) interword = 1'b1;
        else      interchar = 1'b1;
        @(posedge clk); #1;
        interword = 1'b0;
        interchar = 1'b0;
        cycles(4);
    endtask

    task automatic compare_out(input string nm);
        check({nm, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_char%0d", nm, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2, 5'b00001, 1'b0, 1, 8'h41, 8'h00}; // A
        vecs[1]  = '{4, 5'b01000, 1'b1, 2, 8'h42, 8'h20}; // B + space
        vecs[2]  = '{4, 5'b01010, 1'b0, 1, 8'h43, 8'h00}; // C
        vecs[3]  = '{5, 5'b00000, 1'b0, 1, 8'h35, 8'h00}; // 5
        vecs[4]  = '{5, 5'b11111, 1'b1, 2, 8'h30, 8'h20}; // 0 + space
        vecs[5]  = '{4, 5'b00101, 1'b0, 1, 8'h3F, 8'h00}; // .-.- unmapped
        vecs[6]  = '{4, 5'b01100, 1'b0, 1, 8'h5A, 8'h00}; // Z
        vecs[7]  = '{5, 5'b11110, 1'b0, 1, 8'h39, 8'h00}; // 9
        vecs[8]  = '{5, 5'b01111, 1'b0, 1, 8'h31, 8'h00}; // 1
        vecs[9]  = '{3, 5'b00010, 1'b0, 1, 8'h52, 8'h00}; // R
        vecs[10] = '{3, 5'b00101, 1'b1, 2, 8'h4B, 8'h20}; // K + space

        reset = 1'b1; dot = 0; dash = 0; interchar = 0; interword = 0; out_ready = 1'b1;
        cycles(3);
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 0);
        check("rst_pending_len", pending_len, 0);
        check("rst_sym_overflow", sym_overflow, 0);
        check("rst_lost", lost, 0);

        // Word gap straight after reset must not emit a leading space.
        gap(1'b1);
        compare_out("lead_space");

        // Latency of 'A': valid two cycles after the interchar event cycle.
        out_ready = 1'b0;
        send_sym(1'b0);
        send_sym(1'b1);
        check("a_pending_len", pending_len, 2);
        @(posedge clk); #1 interchar = 1'b1;
        @(posedge clk); #1 interchar = 1'b0;
        check("a_valid_k1", out_valid, 0);
        @(posedge clk); #1;
        check("a_valid_k2", out_valid, 1);
        check("a_char_k2", out_char, 8'h41);
        check("a_len_clr", pending_len, 0);
        out_ready = 1'b1;
        cycles(3);
        exp_q.push_back(8'h41);
        compare_out("a_latency");

        for (int v = 0; v < 11; v++) begin
            for (int b = vecs[v].n - 1; b >= 0; b--) send_sym(vecs[v].pat[b]);
            gap(vecs[v].word);
            exp_q.push_back(vecs[v].e0);
            if (vecs[v].nexp > 1) exp_q.push_back(vecs[v].e1);
            compare_out($sformatf("vec%0d", v));
        end

        // Six dots: the sixth is dropped and flags overflow.
        repeat (5) send_sym(1'b0);
        check("ovf_before", sym_overflow, 0);
        send_sym(1'b0);
        check("ovf_flag", sym_overflow, 1);
        check("ovf_len", pending_len, 5);
        gap(1'b0);
        check("ovf_clr", sym_overflow, 0);
        check("ovf_len_clr", pending_len, 0);
        exp_q.push_back(8'h3F);
        compare_out("ovf");

        // 'E' then two word gaps gives exactly one space.
        send_sym(1'b0);
        gap(1'b1);
        gap(1'b1);
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h20);
        compare_out("space_supp");

        // Fill the FIFO; the fifth character is lost.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("full_lost_before", lost, 0);
            send_sym(i[0]);
            gap(1'b0);
        end
        check("full_lost", lost, 1);
        check("full_valid", out_valid, 1);
        check("full_head", out_char, 8'h45);
        out_ready = 1'b1;
        cycles(6);
        check("full_drained", out_valid, 0);
        check("full_lost_sticky", lost, 1);
        exp_q.push_back(8'h45); exp_q.push_back(8'h54);
        exp_q.push_back(8'h45); exp_q.push_back(8'h54);
        compare_out("full");

        // Held dot level counts once; simultaneous dot+dash is a dash.
        @(posedge clk); #1 dot = 1'b1;
        cycles(10);
        dot = 1'b0;
        check("held_len", pending_len, 1);
        gap(1'b0);
        @(posedge clk); #1 dot = 1'b1; dash = 1'b1;
        @(posedge clk); #1 dot = 1'b0; dash = 1'b0;
        check("simul_len", pending_len, 1);
        gap(1'b0);
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h54);
        compare_out("held_simul");

        // Reset mid-pattern discards the partial character.
        send_sym(1'b1);
        send_sym(1'b1);
        do_reset();
        check("midrst_len", pending_len, 0);
        check("midrst_lost", lost, 0);
        send_sym(1'b0);
        gap(1'b0);
        exp_q.push_back(8'h45);
        compare_out("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_morse_decoder
`default_nettype wire

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
Sequencing controller that sits directly after the `timing` block. It turns timing's dot/dash/interchar/interword events into ASCII characters for the display/UART path.
- Accumulates up to 5 Morse symbols per character.
- Decodes the accumulated symbols on a gap event.
- Inserts a single space on word gaps.
- Buffers the results in a small valid/ready output FIFO.

Parameters:
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2.
- UNKNOWN_CHAR, 8'h3F: code emitted for an invalid or overflowed pattern ('?').
- SPACE_CHAR, 8'h20: code emitted on a word gap.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dot  in  1  dot event from timing
- dash  in  1  dash event from timing
- interchar  in  1  character-gap event from timing
- interword  in  1  word-gap event from timing
- out_ready  in  1  consumer accepts the FIFO head
- out_valid  out  1  FIFO not empty
- out_char  out  8  ASCII code at the FIFO head
- pending_len  out  3  number of symbols collected for the current character (0..5)
- sym_overflow  out  1  high while the current pattern holds more than 5 symbols
- lost  out  1  sticky: a character was dropped because the FIFO was full; cleared only by reset

Behaviour:
- Clocking and reset: single clock domain, clk. Reset is synchronous and active-high on `reset`.
- Reset values: out_valid=0, out_char=0, pending_len=0, sym_overflow=0, lost=0. FIFO is emptied, FSM goes to COLLECT, last_space=1 (this suppresses a leading space).
- Edge detection: all four event inputs are rising-edge detected with one register each. A level held for N cycles counts once. The "event cycle" is the cycle where the input is 1 and its previous sample was 0.
- Shift register: pattern[4:0] with dot=0 and dash=1. The update is pattern <= {pattern[3:0], bit}, and len increments. The first symbol ends up at bit len-1.
- Simultaneous dot and dash events: treated as a dash.
- Sixth symbol: pattern and len are left unchanged and sym_overflow is set. Further symbols are also ignored.
- FSM states:
  - COLLECT: accepts symbols.
    - interchar with len>0 or sym_overflow → EMIT_CHAR.
    - interword with len>0 or sym_overflow → EMIT_CHAR, and the space is flagged as pending.
    - interword with len=0 and sym_overflow=0 → EMIT_SPACE if last_space=0, otherwise stay in COLLECT.
    - interchar with len=0 → no action.
    - If interchar and interword fire in the same cycle, interword wins.
  - EMIT_CHAR: one cycle.
    - Writes morse_lut(len, pattern) to the FIFO, or UNKNOWN_CHAR if sym_overflow.
    - Clears pattern, len and sym_overflow, and sets last_space=0.
    - Next state is EMIT_SPACE if a space is pending, otherwise COLLECT.
  - EMIT_SPACE: one cycle. Writes SPACE_CHAR, sets last_space=1, returns to COLLECT.
- Events during EMIT states: dot/dash/gap events arriving in EMIT_CHAR or EMIT_SPACE are ignored.
- Latency: a gap event in cycle k produces the FIFO write at the end of cycle k+1. out_valid is high in cycle k+2. On a word gap, the space follows the character one cycle later.
- FIFO behaviour:
  - Show-ahead: out_char is valid whenever out_valid=1.
  - The head is popped when out_valid && out_ready.
  - A write and a pop in the same cycle are both performed, including when the FIFO is full.
  - A write when full and not popping is dropped and sets lost=1.
  - Pointers wrap modulo FIFO_DEPTH, with one extra bit for the full/empty distinction.
- LUT contents: A–Z and 0–9, standard ITU Morse. Unmapped (len, pattern) combinations give UNKNOWN_CHAR. len=0 is never looked up.
- Reset mid-pattern: the partial pattern is discarded and no character is emitted.

Decomposition:
- Shared package morse_pkg holds:
  - the symbol encoding constants (SYM_DOT=0, SYM_DASH=1);
  - MAX_SYMBOLS=5;
  - the FSM state encoding (COLLECT, EMIT_CHAR, EMIT_SPACE);
  - ASCII constants.
- Sub-module morse_lut: purely combinational; inputs (len[2:0], pattern[4:0]); output char[7:0].
- The FIFO is inline; no separate module.

Test Plan:
- A and B: dot, dash, interchar → single FIFO entry 0x41 ('A'), out_valid high 2 cycles after the interchar edge. Then dash, dot, dot, dot, interword → 0x42 then 0x20 on consecutive writes.
- Overflow: six dots then interchar → sym_overflow=1 after the 6th dot, pending_len stays 5; output is 0x3F, and sym_overflow and pending_len return to 0.
- Space suppression: interword twice with no symbols after 'E' (one dot) → exactly 0x45, 0x20. Interword immediately after reset → no output.
- FIFO full: out_ready=0; emit 5 characters 'E','T','E','T','E' → FIFO holds 0x45, 0x54, 0x45, 0x54, lost=1. Then out_ready=1 → 4 pops in order, then out_valid=0.
- Held level and simultaneous events: dot held high for 10 cycles, then interchar → 'E' (0x45). Dot and dash in the same cycle, then interchar → 'T' (0x54).
- Reset mid-pattern: dash, dash, reset, dot, interchar → only 0x45 is output; pending_len=0 immediately after reset.
